// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/adder4.sv
// WIDTH-bit ripple-carry adder built from full-adder cells.
module adder4
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]         = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mult4_seq.sv
// Sequential unsigned shift-add multiplier: one adder pass per multiplier bit,
// 2*WIDTH-bit product delivered with a single-cycle done pulse.
module mult4_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   acc_sh;
  logic [WIDTH-1:0]   q_sh;
  logic               last_iter;

  adder4 #(.WIDTH(WIDTH)) u_adder (
    .a    (acc),
    .b    (operand),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // The carry-out becomes the accumulator MSB, so the product never overflows.
  assign acc_sh    = {carry, sum[WIDTH-1:1]};
  assign q_sh      = {sum[0], q[WIDTH-1:1]};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    next_state = state;
    operand    = q[0] ? m : '0;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_sh;
          q   <= q_sh;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) p <= {acc_sh, q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq: directed scenarios, held start,
// mid-run reset, randomized ignored starts and an exhaustive operand sweep.
module tb_mult4_seq;

  localparam int W      = 4;
  localparam int LAT    = W + 1;  // cycles from start-sampling edge to done cycle
  localparam int PERIOD = W + 2;  // result spacing with start held high

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int             done_cycle;
    int             done_cnt;
    int             busy_cnt;
    logic [2*W-1:0] p_done;
    bit             p_glitch;
    logic           busy_last;
    logic [2*W-1:0] p_last;
  } obs_t;

  mult4_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply from IDLE and observe ncycles cycles after the accepting edge.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input int pulse_at, input int reset_at, input int ncycles,
                        output obs_t o);
    logic [2*W-1:0] p_prev;
    o.done_cycle = -1;
    o.done_cnt   = 0;
    o.busy_cnt   = 0;
    o.p_done     = '0;
    o.p_glitch   = 1'b0;
    o.busy_last  = 1'b0;
    o.p_last     = '0;
    p_prev = p;
    start = 1'b1;
    a = ai;
    b = bi;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int c = 1; c <= ncycles; c++) begin
      if (busy === 1'b1) o.busy_cnt++;
      if (done === 1'b1) begin
        o.done_cnt++;
        o.done_cycle = c;
        o.p_done     = p;
      end else if (p !== p_prev) begin
        o.p_glitch = 1'b1;
      end
      p_prev      = p;
      o.busy_last = busy;
      o.p_last    = p;
      start = (c == pulse_at);
      if (c == pulse_at) begin
        a = W'(1);
        b = W'(1);
      end
      reset = (c == reset_at);
      if (c < ncycles) tick();
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    checks++;
    if ({busy, done, p} !== '0)
      $display("FAIL reset_state: busy=%b done=%b p=%0d, expected 0 0 0", busy, done, p);
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, p} !== '0)
      $display("FAIL idle_after_reset: busy=%b done=%b p=%0d, expected 0 0 0", busy, done, p);
    if ({busy, done, p} !== '0) failures++;
    if (checks == 2 && failures == 0) ;
  endtask

  task automatic test_max();
    obs_t o;
    run_op(4'd15, 4'd15, -1, -1, PERIOD, o);
    checks++;
    if (o.p_done !== 8'd225) begin
      failures++;
      $display("FAIL max_product: p=%0d expected 225", o.p_done);
    end
    checks++;
    if (o.done_cycle != LAT || o.done_cnt != 1) begin
      failures++;
      $display("FAIL max_latency: done at cycle %0d (%0d pulses) expected cycle %0d (1 pulse)",
               o.done_cycle, o.done_cnt, LAT);
    end
    checks++;
    if (o.busy_cnt != LAT || o.busy_last !== 1'b0) begin
      failures++;
      $display("FAIL max_busy: busy cycles=%0d last=%b expected %0d cycles then 0",
               o.busy_cnt, o.busy_last, LAT);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0]   ta [3] = '{4'd9, 4'd0, 4'd13};
    logic [W-1:0]   tbv[3] = '{4'd7, 4'd13, 4'd0};
    logic [2*W-1:0] te [3] = '{8'd63, 8'd0, 8'd0};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tbv[i], -1, -1, PERIOD, o);
      checks++;
      if (o.p_done !== te[i] || o.done_cycle != LAT || o.done_cnt != 1) begin
        failures++;
        $display("FAIL basic_%0dx%0d: p=%0d at cycle %0d (%0d pulses) expected %0d at cycle %0d",
                 ta[i], tbv[i], o.p_done, o.done_cycle, o.done_cnt, te[i], LAT);
      end
    end
  endtask

  task automatic test_ignored_start();
    obs_t o;
    run_op(4'd12, 4'd11, 2, -1, 2 * PERIOD, o);
    checks++;
    if (o.done_cnt != 1 || o.p_done !== 8'd132 || o.p_last !== 8'd132) begin
      failures++;
      $display("FAIL ignored_start: pulses=%0d p=%0d final p=%0d expected 1 pulse p=132",
               o.done_cnt, o.p_done, o.p_last);
    end
    checks++;
    if (o.busy_cnt != LAT) begin
      failures++;
      $display("FAIL ignored_start_busy: busy cycles=%0d expected %0d", o.busy_cnt, LAT);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t o;
    run_op(4'd11, 4'd6, -1, 3, 7, o);
    checks++;
    if (o.busy_cnt != 3 || o.done_cnt != 0 || o.p_last !== '0 || o.busy_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: busy cycles=%0d pulses=%0d p=%0d expected 3 0 0",
               o.busy_cnt, o.done_cnt, o.p_last);
    end
    run_op(4'd11, 4'd6, -1, -1, PERIOD, o);
    checks++;
    if (o.p_done !== 8'd66 || o.done_cycle != LAT) begin
      failures++;
      $display("FAIL restart_after_reset: p=%0d at cycle %0d expected 66 at cycle %0d",
               o.p_done, o.done_cycle, LAT);
    end
  endtask

  task automatic test_start_held();
    int exp_q[$];
    int dones = 0;
    int exp_p;
    start = 1'b1;
    a = 4'd3;
    b = 4'd5;
    for (int c = 0; c < 4 * PERIOD; c++) begin
      if (c % PERIOD == 0) exp_q.push_back(int'(a) * int'(b));
      if (c == 8)  a = 4'd4;
      if (c == 14) a = 4'd3;
      tick();
      if (done === 1'b1) begin
        dones++;
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if ((c + 1) % PERIOD != LAT || int'(p) != exp_p) begin
          failures++;
          $display("FAIL held_result_%0d: p=%0d at cycle %0d expected %0d at cycle mod %0d = %0d",
                   dones, p, c + 1, exp_p, PERIOD, LAT);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 4) begin
      failures++;
      $display("FAIL held_count: %0d results expected 4", dones);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL held_release: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    obs_t           o;
    logic [W-1:0]   ai;
    logic [W-1:0]   bi;
    logic [2*W-1:0] exp_p;
    for (int i = 0; i < 20; i++) begin
      ai    = W'($urandom);
      bi    = W'($urandom);
      exp_p = ai * bi;
      run_op(ai, bi, $urandom_range(1, LAT), -1, PERIOD, o);
      checks++;
      if (o.p_done !== exp_p || o.done_cnt != 1 || o.busy_last !== 1'b0) begin
        failures++;
        $display("FAIL random_%0dx%0d: p=%0d pulses=%0d busy=%b expected p=%0d 1 pulse busy=0",
                 ai, bi, o.p_done, o.done_cnt, o.busy_last, exp_p);
      end
    end
  endtask

  task automatic test_sweep();
    obs_t           o;
    int             off;
    int             idx;
    logic [W-1:0]   ai;
    logic [W-1:0]   bi;
    logic [2*W-1:0] exp_p;
    off = $urandom_range(255);
    for (int k = 0; k < 256; k++) begin
      idx   = (off + k) % 256;
      ai    = idx[7:4];
      bi    = idx[3:0];
      exp_p = ai * bi;
      run_op(ai, bi, -1, -1, PERIOD, o);
      checks++;
      if (o.p_done !== exp_p || o.done_cycle != LAT || o.done_cnt != 1 ||
          o.p_glitch || o.busy_last !== 1'b0) begin
        failures++;
        $display("FAIL sweep_%0dx%0d: p=%0d cycle=%0d pulses=%0d glitch=%0d busy=%b expected p=%0d cycle=%0d",
                 ai, bi, o.p_done, o.done_cycle, o.done_cnt, o.p_glitch, o.busy_last, exp_p, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_basic();
    test_ignored_start();
    test_reset_mid_run();
    test_start_held();
    test_random();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
